// File: rtl/cl_axil_mbox_pkg.sv
// Shared definitions for the AXI-Lite mailbox responder:
// register offsets, response codes, ISR bits, FSM states.
package cl_axil_mbox_pkg;

   localparam logic [11:0] REG_TX_DATA = 12'h000;
   localparam logic [11:0] REG_TX_VAC  = 12'h004;
   localparam logic [11:0] REG_RX_DATA = 12'h008;
   localparam logic [11:0] REG_RX_OCC  = 12'h00C;
   localparam logic [11:0] REG_ISR     = 12'h010;
   localparam logic [11:0] REG_IER     = 12'h014;
   localparam logic [11:0] REG_SCRATCH = 12'h018;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int ISR_TX_OVF = 0;
   localparam int ISR_RX_UNF = 1;
   localparam int ISR_RX_NE  = 2;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_e;

   function automatic logic [11:0] reg_off(input logic [31:0] a);
      return {a[11:2], 2'b00};
   endfunction

endpackage

// File: rtl/axil_mbox_fifo.sv
// Single-clock 1r1w word FIFO with occupancy output.
// Push while full and pop while empty are ignored.
module axil_mbox_fifo #(
   parameter int DEPTH_P = 16,
   parameter int WIDTH_P = 32,
   localparam int AW = $clog2(DEPTH_P),
   localparam int CW = AW + 1
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic               pop_i,
   output logic [WIDTH_P-1:0] data_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [CW-1:0]      count_o
);

   logic [WIDTH_P-1:0] mem [DEPTH_P];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               do_push;
   logic               do_pop;

   assign full_o  = (count == CW'(DEPTH_P));
   assign empty_o = (count == '0);
   assign count_o = count;
   assign data_o  = mem[rd_ptr];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Storage write; contents need no reset
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

   // Pointers wrap naturally since depth is a power of 2
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/axil_mailbox_responder.sv
// AXI-Lite mailbox endpoint: TX/RX word FIFOs plus status regs.
// AXIL_MBOX_LOOPBACK_EN routes the TX FIFO head into the RX FIFO.
module axil_mailbox_responder
   import cl_axil_mbox_pkg::*;
#(
   parameter int FIFO_DEPTH_P = 16,
   parameter int DATA_WIDTH_P = 32
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [31:0] s_awaddr_i,
   input  logic        s_awvalid_i,
   output logic        s_awready_o,
   input  logic [31:0] s_wdata_i,
   input  logic [3:0]  s_wstrb_i,
   input  logic        s_wvalid_i,
   output logic        s_wready_o,
   output logic [1:0]  s_bresp_o,
   output logic        s_bvalid_o,
   input  logic        s_bready_i,
   input  logic [31:0] s_araddr_i,
   input  logic        s_arvalid_i,
   output logic        s_arready_o,
   output logic [31:0] s_rdata_o,
   output logic [1:0]  s_rresp_o,
   output logic        s_rvalid_o,
   input  logic        s_rready_i,
   output logic [31:0] tx_data_o,
   output logic        tx_v_o,
   input  logic        tx_yumi_i,
   input  logic [31:0] rx_data_i,
   input  logic        rx_v_i,
   output logic        rx_ready_o,
   output logic        irq_o
);

   localparam int CW = $clog2(FIFO_DEPTH_P) + 1;

   wr_state_e   w_state, w_next;
   rd_state_e   r_state, r_next;
   logic        live_q;
   logic [11:0] aw_off_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic [1:0]  isr_q;
   logic [2:0]  ier_q;
   logic [31:0] scratch_q;
   logic        irq_q;

   logic        aw_hs, w_hs, ar_hs, wr_fire;
   logic [11:0] wr_off, rd_off;
   logic [31:0] wr_data, rd_val;
   logic [3:0]  wr_strb;
   logic [1:0]  wr_resp, rd_resp, isr_clr;
   logic        set_ovf, set_unf, ier_we, scr_we;
   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic [31:0] tx_head, rx_head, rx_wdata;
   logic [CW-1:0] tx_count, rx_count;
   logic        unused_bits;

   assign s_awready_o = live_q & ((w_state == W_IDLE) |
                                  (w_state == W_HAVE_W));
   assign s_wready_o  = live_q & ((w_state == W_IDLE) |
                                  (w_state == W_HAVE_AW));
   assign s_bvalid_o  = (w_state == W_RESP);
   assign s_bresp_o   = bresp_q;
   assign s_arready_o = live_q & (r_state == R_IDLE);
   assign s_rvalid_o  = (r_state == R_RESP);
   assign s_rdata_o   = rdata_q;
   assign s_rresp_o   = rresp_q;
   assign irq_o       = irq_q;
   assign tx_data_o   = tx_head;

   assign aw_hs   = s_awvalid_i & s_awready_o;
   assign w_hs    = s_wvalid_i & s_wready_o;
   assign ar_hs   = s_arvalid_i & s_arready_o;
   assign wr_off  = (w_state == W_HAVE_AW) ? aw_off_q
                                           : reg_off(s_awaddr_i);
   assign wr_data = (w_state == W_HAVE_W) ? wdata_q : s_wdata_i;
   assign wr_strb = (w_state == W_HAVE_W) ? wstrb_q : s_wstrb_i;
   assign rd_off  = reg_off(s_araddr_i);

`ifdef AXIL_MBOX_LOOPBACK_EN
   assign tx_pop      = ~tx_empty & ~rx_full;
   assign rx_push     = tx_pop;
   assign rx_wdata    = tx_head;
   assign tx_v_o      = 1'b0;
   assign rx_ready_o  = 1'b0;
   assign unused_bits = ^{s_awaddr_i[31:12], s_awaddr_i[1:0],
                          s_araddr_i[31:12], s_araddr_i[1:0],
                          tx_yumi_i, rx_v_i, rx_data_i};
`else
   assign tx_pop      = tx_yumi_i;
   assign rx_push     = rx_v_i & live_q;
   assign rx_wdata    = rx_data_i;
   assign tx_v_o      = ~tx_empty;
   assign rx_ready_o  = live_q & ~rx_full;
   assign unused_bits = ^{s_awaddr_i[31:12], s_awaddr_i[1:0],
                          s_araddr_i[31:12], s_araddr_i[1:0]};
`endif

   axil_mbox_fifo #(.DEPTH_P(FIFO_DEPTH_P), .WIDTH_P(DATA_WIDTH_P))
   u_tx_fifo (
      .clk_i   (clk_i),
      .reset_n_i(reset_n_i),
      .push_i  (tx_push),
      .data_i  (wr_data),
      .pop_i   (tx_pop),
      .data_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count)
   );

   axil_mbox_fifo #(.DEPTH_P(FIFO_DEPTH_P), .WIDTH_P(DATA_WIDTH_P))
   u_rx_fifo (
      .clk_i   (clk_i),
      .reset_n_i(reset_n_i),
      .push_i  (rx_push),
      .data_i  (rx_wdata),
      .pop_i   (rx_pop),
      .data_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_count)
   );

   // State registers; live_q holds readies low until first edge
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         live_q  <= 1'b0;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         live_q  <= 1'b1;
      end
   end

   // Write FSM: gather AW and W in any order, then respond
   always_comb begin
      w_next  = w_state;
      wr_fire = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_next  = W_RESP;
               wr_fire = 1'b1;
            end else if (aw_hs) begin
               w_next = W_HAVE_AW;
            end else if (w_hs) begin
               w_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_hs) begin
            w_next  = W_RESP;
            wr_fire = 1'b1;
         end
         W_HAVE_W: if (aw_hs) begin
            w_next  = W_RESP;
            wr_fire = 1'b1;
         end
         W_RESP: if (s_bready_i) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Read FSM: single outstanding read, held until rready
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_RESP;
         R_RESP:  if (s_rready_i) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Write decode: side effects fire once per completed write
   always_comb begin
      tx_push = 1'b0;
      set_ovf = 1'b0;
      isr_clr = 2'b00;
      ier_we  = 1'b0;
      scr_we  = 1'b0;
      wr_resp = RESP_OKAY;
      case (wr_off)
         REG_TX_DATA: begin
            if (tx_full) begin
               wr_resp = RESP_SLVERR;
               set_ovf = wr_fire;
            end else begin
               tx_push = wr_fire;
            end
         end
         REG_ISR:     isr_clr = wr_fire ? wr_data[1:0] : 2'b00;
         REG_IER:     ier_we  = wr_fire;
         REG_SCRATCH: scr_we  = wr_fire;
         default:     wr_resp = RESP_SLVERR;
      endcase
   end

   // Read decode: RX pop happens at AR acceptance
   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_OKAY;
      rx_pop  = 1'b0;
      set_unf = 1'b0;
      case (rd_off)
         REG_TX_VAC:  rd_val = 32'(FIFO_DEPTH_P) - 32'(tx_count);
         REG_RX_DATA: begin
            if (rx_empty) begin
               rd_resp = RESP_SLVERR;
               set_unf = ar_hs;
            end else begin
               rd_val = rx_head;
               rx_pop = ar_hs;
            end
         end
         REG_RX_OCC:  rd_val = 32'(rx_count);
         REG_ISR:     rd_val = {29'd0, ~rx_empty, isr_q};
         REG_IER:     rd_val = {29'd0, ier_q};
         REG_SCRATCH: rd_val = scratch_q;
         default:     rd_resp = RESP_SLVERR;
      endcase
   end

   // Bus capture and response registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         aw_off_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs)   aw_off_q <= reg_off(s_awaddr_i);
         if (w_hs)    wdata_q  <= s_wdata_i;
         if (w_hs)    wstrb_q  <= s_wstrb_i;
         if (wr_fire) bresp_q  <= wr_resp;
         if (ar_hs)   rdata_q  <= rd_val;
         if (ar_hs)   rresp_q  <= rd_resp;
      end
   end

   // Control registers; a same-cycle set beats a W1C clear
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         isr_q     <= '0;
         ier_q     <= '0;
         scratch_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         isr_q <= (isr_q & ~isr_clr) | {set_unf, set_ovf};
         if (ier_we && wr_strb[0]) ier_q <= wr_data[2:0];
         for (int b = 0; b < 4; b++) begin
            if (scr_we && wr_strb[b])
               scratch_q[8*b +: 8] <= wr_data[8*b +: 8];
         end
         irq_q <= |({~rx_empty, isr_q} & ier_q);
      end
   end

endmodule

// File: tb/tb_axil_mailbox_responder.sv
// Directed bench for axil_mailbox_responder.
// Define AXIL_MBOX_LOOPBACK_EN to exercise the loopback build.
module tb_axil_mailbox_responder;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic [31:0] s_awaddr_i = '0;
   logic        s_awvalid_i = 1'b0;
   logic        s_awready_o;
   logic [31:0] s_wdata_i = '0;
   logic [3:0]  s_wstrb_i = '0;
   logic        s_wvalid_i = 1'b0;
   logic        s_wready_o;
   logic [1:0]  s_bresp_o;
   logic        s_bvalid_o;
   logic        s_bready_i = 1'b0;
   logic [31:0] s_araddr_i = '0;
   logic        s_arvalid_i = 1'b0;
   logic        s_arready_o;
   logic [31:0] s_rdata_o;
   logic [1:0]  s_rresp_o;
   logic        s_rvalid_o;
   logic        s_rready_i = 1'b0;
   logic [31:0] tx_data_o;
   logic        tx_v_o;
   logic        tx_yumi_i = 1'b0;
   logic [31:0] rx_data_i = '0;
   logic        rx_v_i = 1'b0;
   logic        rx_ready_o;
   logic        irq_o;

   int  nvec = 0;
   int  nerr = 0;
   bit  fab_en = 1'b0;

   axil_mailbox_responder dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .s_awaddr_i (s_awaddr_i),
      .s_awvalid_i(s_awvalid_i),
      .s_awready_o(s_awready_o),
      .s_wdata_i  (s_wdata_i),
      .s_wstrb_i  (s_wstrb_i),
      .s_wvalid_i (s_wvalid_i),
      .s_wready_o (s_wready_o),
      .s_bresp_o  (s_bresp_o),
      .s_bvalid_o (s_bvalid_o),
      .s_bready_i (s_bready_i),
      .s_araddr_i (s_araddr_i),
      .s_arvalid_i(s_arvalid_i),
      .s_arready_o(s_arready_o),
      .s_rdata_o  (s_rdata_o),
      .s_rresp_o  (s_rresp_o),
      .s_rvalid_o (s_rvalid_o),
      .s_rready_i (s_rready_i),
      .tx_data_o  (tx_data_o),
      .tx_v_o     (tx_v_o),
      .tx_yumi_i  (tx_yumi_i),
      .rx_data_i  (rx_data_i),
      .rx_v_i     (rx_v_i),
      .rx_ready_o (rx_ready_o),
      .irq_o      (irq_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // gap > 0: W trails AW; gap < 0: AW trails W; 0: same cycle
   task automatic wr(input string tag, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input int gap, input logic [1:0] er);
      int cyc, aw_at, w_at;
      bit awd, wd, aw_hs, w_hs;
      aw_at = (gap < 0) ? -gap : 0;
      w_at  = (gap > 0) ? gap : 0;
      cyc = 0; awd = 0; wd = 0;
      s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
      while (!(awd && wd) && cyc < 64) begin
         if (!awd && cyc >= aw_at) s_awvalid_i = 1'b1;
         if (!wd && cyc >= w_at)   s_wvalid_i  = 1'b1;
         aw_hs = s_awvalid_i && s_awready_o;
         w_hs  = s_wvalid_i && s_wready_o;
         tick();
         if (aw_hs) begin awd = 1; s_awvalid_i = 1'b0; end
         if (w_hs)  begin wd = 1;  s_wvalid_i  = 1'b0; end
         cyc++;
      end
      s_awvalid_i = 1'b0;
      s_wvalid_i  = 1'b0;
      chk({tag, ".bvalid"}, 32'(s_bvalid_o), 32'd1);
      chk({tag, ".bresp"}, 32'(s_bresp_o), 32'(er));
      s_bready_i = 1'b1;
      tick();
      s_bready_i = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input int stall, input logic [31:0] ed,
                     input logic [1:0] er);
      int cyc;
      bit hs;
      s_araddr_i = a; s_arvalid_i = 1'b1;
      cyc = 0; hs = 0;
      while (!hs && cyc < 64) begin
         hs = s_arready_o;
         tick();
         cyc++;
      end
      s_arvalid_i = 1'b0;
      chk({tag, ".rvalid"}, 32'(s_rvalid_o), 32'd1);
      chk({tag, ".rdata"}, s_rdata_o, ed);
      chk({tag, ".rresp"}, 32'(s_rresp_o), 32'(er));
      for (int i = 0; i < stall; i++) begin
         tick();
         chk({tag, ".hold"}, s_rdata_o, ed);
         chk({tag, ".holdv"}, 32'(s_rvalid_o), 32'd1);
      end
      s_rready_i = 1'b1;
      tick();
      s_rready_i = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) tick();
      chk("rst.awready", 32'(s_awready_o), 0);
      chk("rst.wready", 32'(s_wready_o), 0);
      chk("rst.arready", 32'(s_arready_o), 0);
      chk("rst.bvalid", 32'(s_bvalid_o), 0);
      chk("rst.rvalid", 32'(s_rvalid_o), 0);
      chk("rst.rdata", s_rdata_o, 0);
      chk("rst.irq", 32'(irq_o), 0);
      chk("rst.tx_v", 32'(tx_v_o), 0);
      chk("rst.rx_ready", 32'(rx_ready_o), 0);
      reset_n_i = 1'b1;
      #1;
      chk("rel.awready_pre", 32'(s_awready_o), 0);
      tick();
      chk("rel.awready", 32'(s_awready_o), 1);
      chk("rel.arready", 32'(s_arready_o), 1);

      // scratch, AW before W
      wr("t1.w", 32'h018, 32'hDEADBEEF, 4'hF, 3, OK);
      rd("t1.r", 32'h018, 0, 32'hDEADBEEF, OK);

      // byte enables, W before AW; bad offsets
      wr("t5.wbyte", 32'h018, 32'h00001234, 4'b0011, -2, OK);
      rd("t5.rbyte", 32'h018, 0, 32'hDEAD1234, OK);
      wr("t5.wro", 32'h004, 32'hFFFFFFFF, 4'hF, 0, ERR);
      rd("t5.rbad", 32'h100, 0, 32'h0, ERR);
      rd("t5.rtxd", 32'h000, 0, 32'h0, ERR);
      rd("t5.vac", 32'h004, 0, 32'd16, OK);
      rd("t5.isr", 32'h010, 0, 32'h0, OK);
      rd("t5.scr", 32'h018, 0, 32'hDEAD1234, OK);

`ifndef AXIL_MBOX_LOOPBACK_EN
      // TX overflow
      wr("t2.ier", 32'h014, 32'h1, 4'hF, 0, OK);
      for (int i = 0; i < 17; i++)
         wr("t2.push", 32'h000, 32'hA0 + i, 4'hF, 0,
            (i < 16) ? OK : ERR);
      rd("t2.vac0", 32'h004, 0, 32'd0, OK);
      rd("t2.isr", 32'h010, 0, 32'h1, OK);
      chk("t2.irq", 32'(irq_o), 1);
      chk("t2.tx_v", 32'(tx_v_o), 1);
      tx_yumi_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t2.txdata", tx_data_o, 32'hA0 + i);
         tick();
      end
      tx_yumi_i = 1'b0;
      chk("t2.tx_v0", 32'(tx_v_o), 0);
      rd("t2.vac16", 32'h004, 0, 32'd16, OK);
      wr("t2.clr", 32'h010, 32'h1, 4'hF, 0, OK);
      rd("t2.isr0", 32'h010, 0, 32'h0, OK);
      tick();
      chk("t2.irq0", 32'(irq_o), 0);
      wr("t2.ier0", 32'h014, 32'h0, 4'hF, 0, OK);
`endif

      // RX underflow and W1C
      rd("t3.pop", 32'h008, 0, 32'h0, ERR);
      rd("t3.isr", 32'h010, 0, 32'h2, OK);
      wr("t3.clr", 32'h010, 32'h2, 4'hF, 0, OK);
      rd("t3.isr0", 32'h010, 0, 32'h0, OK);

`ifndef AXIL_MBOX_LOOPBACK_EN
      // fabric streams while host reads with a stall
      rx_data_i = 32'h100;
      fab_en = 1'b1;
      fork
         begin
            bit hs;
            int k;
            k = 0;
            rx_v_i = 1'b1;
            while (fab_en && k < 400) begin
               hs = rx_v_i && rx_ready_o;
               tick();
               if (hs) rx_data_i = rx_data_i + 1;
               k++;
            end
            rx_v_i = 1'b0;
         end
      join_none
      repeat (2) tick();
      rd("t4.stall", 32'h008, 5, 32'h100, OK);
      for (int i = 1; i < 6; i++)
         rd("t4.pop", 32'h008, 0, 32'h100 + i, OK);
      n = 0;
      while (rx_ready_o && n < 64) begin tick(); n++; end
      fab_en = 1'b0;
      repeat (3) tick();
      rd("t4.occ", 32'h00C, 0, 32'd16, OK);
      rd("t4.isr", 32'h010, 0, 32'h4, OK);
      for (int i = 0; i < 16; i++)
         rd("t4.drain", 32'h008, 0, 32'h106 + i, OK);
      rd("t4.occ0", 32'h00C, 0, 32'd0, OK);
`else
      wr("lb.w", 32'h000, 32'h12345678, 4'hF, 0, OK);
      repeat (3) tick();
      chk("lb.tx_v", 32'(tx_v_o), 0);
      chk("lb.rx_ready", 32'(rx_ready_o), 0);
      rd("lb.r", 32'h008, 0, 32'h12345678, OK);
`endif

      // reset with a write response pending
      rd("t6.unf", 32'h008, 0, 32'h0, ERR);
      wr("t6.push", 32'h000, 32'h77, 4'hF, 0, OK);
      wr("t6.ier", 32'h014, 32'h7, 4'hF, 0, OK);
      s_awaddr_i = 32'h018; s_wdata_i = 32'h55; s_wstrb_i = 4'hF;
      s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
      tick();
      s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
      chk("t6.bvalid", 32'(s_bvalid_o), 1);
      reset_n_i = 1'b0;
      #1;
      chk("t6.bvalid0", 32'(s_bvalid_o), 0);
      chk("t6.awready0", 32'(s_awready_o), 0);
      chk("t6.irq0", 32'(irq_o), 0);
      chk("t6.tx_v0", 32'(tx_v_o), 0);
      repeat (2) tick();
      reset_n_i = 1'b1;
      tick();
      chk("t6.bvalid_after", 32'(s_bvalid_o), 0);
      rd("t6.vac", 32'h004, 0, 32'd16, OK);
      rd("t6.occ", 32'h00C, 0, 32'd0, OK);
      rd("t6.isr", 32'h010, 0, 32'h0, OK);
      rd("t6.ier", 32'h014, 0, 32'h0, OK);
      rd("t6.scr", 32'h018, 0, 32'h0, OK);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
